// File: rtl/sw_seq_feeder.sv
// Smith-Waterman feeder: buffers one packed S/T job, replays it as a gap-free 2-bit base burst and
// returns the core's max score. Define SW_TIMEOUT_EN to add a WAIT timeout and the res_err output.
module sw_seq_feeder #(
    parameter int unsigned SEQ_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [1:0]  data_s,
    output logic [1:0]  data_t,
    output logic        valid,
    input  logic        sw_finish,
    input  logic [11:0] sw_max,
    output logic        res_valid,
    output logic [11:0] res_data,
    input  logic        res_ready,
`ifdef SW_TIMEOUT_EN
    output logic        res_err,
`endif
    output logic        busy
);

    localparam int unsigned WORDS = SEQ_LEN / 4;
    localparam int unsigned PtrW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned IdxW  = $clog2(SEQ_LEN);
    localparam logic [PtrW-1:0] LastWord = PtrW'(WORDS - 1);
    localparam logic [IdxW-1:0] LastBase = IdxW'(SEQ_LEN - 1);
`ifdef SW_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 2 * SEQ_LEN + 8;
    localparam logic [9:0]  TimeoutLast   = 10'(TimeoutCycles - 1);
`endif

    typedef enum logic [1:0] {
        StLoad,
        StStream,
        StWait,
        StResult
    } state_e;

    state_e          state_q;
    logic [15:0]     buf_q [WORDS];
    logic [PtrW-1:0] wr_ptr_q;
    logic            buf_full_q;
    logic [IdxW-1:0] rd_idx_q;
`ifdef SW_TIMEOUT_EN
    logic [9:0]      wait_cnt_q;
`endif

    logic            accept;
    logic            last_accept;
    logic            full_now;
    logic [IdxW-1:0] nxt_idx;
    logic [PtrW-1:0] rd_word;
    logic [15:0]     word;
    logic [1:0]      nxt_s;
    logic [1:0]      nxt_t;

    assign in_ready    = !buf_full_q && (state_q != StStream);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (wr_ptr_q == LastWord);
    assign full_now    = buf_full_q || last_accept;
    assign busy        = (state_q != StLoad);

    // Base fetched for the next cycle: index 0 when a burst starts, otherwise rd_idx+1.
    // The bypass covers a word being written on the same edge it is first read.
    always_comb begin
        nxt_idx = (state_q == StStream) ? rd_idx_q + 1'b1 : '0;
        rd_word = PtrW'(nxt_idx >> 2);
        word    = (accept && (wr_ptr_q == rd_word)) ? in_data : buf_q[rd_word];
        nxt_s   = 2'b00;
        nxt_t   = 2'b00;
        case (nxt_idx[1:0])
            2'd0: begin nxt_s = word[9:8];   nxt_t = word[1:0]; end
            2'd1: begin nxt_s = word[11:10]; nxt_t = word[3:2]; end
            2'd2: begin nxt_s = word[13:12]; nxt_t = word[5:4]; end
            default: begin nxt_s = word[15:14]; nxt_t = word[7:6]; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StLoad;
            wr_ptr_q   <= '0;
            buf_full_q <= 1'b0;
            rd_idx_q   <= '0;
            data_s     <= 2'b00;
            data_t     <= 2'b00;
            valid      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
`ifdef SW_TIMEOUT_EN
            res_err    <= 1'b0;
            wait_cnt_q <= '0;
`endif
        end else begin
            if (accept) begin
                if (last_accept) begin
                    wr_ptr_q   <= '0;
                    buf_full_q <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
            case (state_q)
                StLoad: begin
                    if (full_now) begin
                        state_q  <= StStream;
                        valid    <= 1'b1;
                        data_s   <= nxt_s;
                        data_t   <= nxt_t;
                        rd_idx_q <= '0;
                    end
                end
                StStream: begin
                    if (rd_idx_q == LastBase) begin
                        state_q    <= StWait;
                        valid      <= 1'b0;
                        data_s     <= 2'b00;
                        data_t     <= 2'b00;
                        buf_full_q <= 1'b0;
                        rd_idx_q   <= '0;
`ifdef SW_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        rd_idx_q <= nxt_idx;
                        data_s   <= nxt_s;
                        data_t   <= nxt_t;
                    end
                end
                StWait: begin
                    if (sw_finish) begin
                        state_q   <= StResult;
                        res_valid <= 1'b1;
                        res_data  <= sw_max;
`ifdef SW_TIMEOUT_EN
                        res_err   <= 1'b0;
                    end else if (wait_cnt_q == TimeoutLast) begin
                        state_q   <= StResult;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 10'd1;
`endif
                    end
                end
                StResult: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (full_now) begin
                            state_q  <= StStream;
                            valid    <= 1'b1;
                            data_s   <= nxt_s;
                            data_t   <= nxt_t;
                            rd_idx_q <= '0;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule
